// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter and memory address generator (mos6502 core)
//
// Sits directly after the control FSM. It turns the PC-step (ps) and
// address-select (mm) controls into a program counter and a memory address.
// When the vector fetch is built in, the unit reads the 6502 reset vector
// first and keeps `ready` low until the PC holds the vector value.
//
// Build option:
//   PC_VECTOR_FETCH_EN  defined   -> reset vector fetch (VLO -> VHI -> VLD -> RUN)
//                       undefined -> no fetch; reset loads RESET_PC, unit
//                                    runs from the next cycle
//
// Ports:
//   clk        in   1    core clock, all state changes on posedge
//   reset      in   1    synchronous, active-high reset
//   ps         in   2    PC step: 2'b01 = INC, any other value = HOLD
//   mm         in   2    address select: 2'b00 = PC_ADDR (pc), any other = ea
//   pc_load    in   1    load pc from pc_din; wins over ps
//   pc_din     in   AW   jump / branch target
//   ea         in   AW   effective address from the operand stage
//   mem_rdata  in   8    synchronous RAM read data (1-cycle latency)
//   addr       out  AW   memory address bus (combinational)
//   pc         out  AW   program counter (registered)
//   ready      out  1    PC valid; the unit obeys ps / pc_load (registered)
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RST_VEC  = 16'hFFFC,
    parameter logic [AW-1:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    ps,
    input  logic [1:0]    mm,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_din,
    input  logic [AW-1:0] ea,
    input  logic [7:0]    mem_rdata,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] pc,
    output logic          ready
);

    // Encodings shared with the control FSM. Only the decoded values
    // are named; every other ps code behaves as HOLD.
    localparam logic [1:0] PS_INC     = 2'b01;
    localparam logic [1:0] MM_PC_ADDR = 2'b00;

    logic [AW-1:0] r_pc;
    logic          r_ready;

    // Run-mode next PC: a load beats the step, and the increment wraps
    // silently at the top of the address space.
    logic [AW-1:0] w_pc_run_nxt;
    // Run-mode address: pc or effective address, with no register stage.
    logic [AW-1:0] w_run_addr;

    assign w_pc_run_nxt = pc_load        ? pc_din
                        : (ps == PS_INC) ? r_pc + AW'(1)
                        :                  r_pc;

    assign w_run_addr = (mm == MM_PC_ADDR) ? r_pc : ea;

    assign pc    = r_pc;
    assign ready = r_ready;

`ifdef PC_VECTOR_FETCH_EN

    typedef enum logic [1:0] {
        S_VLO = 2'd0,   // present vector low-byte address
        S_VHI = 2'd1,   // present high-byte address, low byte arriving
        S_VLD = 2'd2,   // high byte arriving, load pc
        S_RUN = 2'd3    // normal operation, absorbing until reset
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_lo;
    logic          w_lo_en;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_vec_hi;
    logic [AW-1:0] w_unused_reset_pc;

    assign w_vec_hi          = RST_VEC + AW'(1);
    assign w_unused_reset_pc = RESET_PC;

    // NOTE: every signal written here gets a default before the case so
    // no path leaves it unassigned; an unassigned path would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_lo_en     = 1'b0;
        addr        = RST_VEC;
        case (r_state)
            S_VLO: begin
                addr        = RST_VEC;
                w_state_nxt = S_VHI;
            end
            S_VHI: begin
                // RAM returns the byte addressed during VLO.
                addr        = w_vec_hi;
                w_lo_en     = 1'b1;
                w_state_nxt = S_VLD;
            end
            S_VLD: begin
                // Address held so the bus stays stable; RAM returns the
                // high byte addressed during VHI.
                addr        = w_vec_hi;
                w_pc_nxt    = AW'({mem_rdata, r_lo});
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                addr        = w_run_addr;
                w_pc_nxt    = w_pc_run_nxt;
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_VLO;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so that every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_VLO;
            r_pc    <= '0;
            r_lo    <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_lo_en) begin
                r_lo <= mem_rdata;
            end
            // Registered copy of "next state is RUN" so ready rises
            // together with the vector value appearing on pc.
            r_ready <= (w_state_nxt == S_RUN);
        end
    end

`else

    // No vector fetch: read data and vector address are not needed.
    logic w_unused_bits;
    assign w_unused_bits = ^{mem_rdata, RST_VEC};

    assign addr = w_run_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_ready <= 1'b0;
        end else begin
            r_pc    <= w_pc_run_nxt;
            r_ready <= 1'b1;
        end
    end

`endif

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit.
// A driver applies directed and random stimulus once per cycle on the falling
// edge and pushes the outputs the reference model predicts for that cycle
// into a scoreboard. A monitor pops one entry per cycle and compares it with
// ready / pc / addr. Covers both builds of PC_VECTOR_FETCH_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_unit;

    localparam int          AW       = 16;
    localparam logic [1:0]  PS_HOLD  = 2'b00;
    localparam logic [1:0]  PS_INC   = 2'b01;
    localparam logic [1:0]  MM_PC    = 2'b00;
    localparam logic [1:0]  MM_EA    = 2'b01;
    localparam logic [15:0] RST_VEC  = 16'hFFFC;
    localparam logic [15:0] RESET_PC = 16'h8000;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    ps;
    logic [1:0]    mm;
    logic          pc_load;
    logic [AW-1:0] pc_din;
    logic [AW-1:0] ea;
    logic [7:0]    mem_rdata;
    logic [AW-1:0] addr;
    logic [AW-1:0] pc;
    logic          ready;

    pc_unit #(
        .AW       (AW),
        .RST_VEC  (RST_VEC),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps        (ps),
        .mm        (mm),
        .pc_load   (pc_load),
        .pc_din    (pc_din),
        .ea        (ea),
        .mem_rdata (mem_rdata),
        .addr      (addr),
        .pc        (pc),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, one cycle of read latency.
    logic [7:0] mem [0:65535];
    always @(posedge clk) mem_rdata <= mem[addr];

    typedef struct {
        logic        rdy;
        logic [15:0] pc;
        logic [15:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: cycles since reset plus the architectural PC.
    bit          m_known = 1'b0;
    int          m_since = 0;      // edges seen since reset, saturating at 3
    logic [15:0] m_pc    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] run_step(input logic [15:0] cur, input logic [1:0] p,
                                             input bit ld, input logic [15:0] din);
        int nxt;
        if (ld) return din;
        if (p == PS_INC) begin
            nxt = (int'(cur) + 1) % 65536;
            return nxt[15:0];
        end
        return cur;
    endfunction

    // One clock cycle of stimulus: drive, predict this cycle, advance model.
    task automatic drive(input bit rst, input logic [1:0] p, input logic [1:0] m,
                         input bit ld, input logic [15:0] din, input logic [15:0] e);
        exp_t x;
        logic [15:0] sel;
        @(negedge clk);
        reset   = rst;
        ps      = p;
        mm      = m;
        pc_load = ld;
        pc_din  = din;
        ea      = e;
        sel = (m == MM_PC) ? m_pc : e;
        if (m_known) begin
            x.pc = m_pc;
`ifdef PC_VECTOR_FETCH_EN
            x.rdy  = (m_since >= 3);
            x.addr = (m_since == 0) ? RST_VEC : (m_since < 3) ? RST_VEC + 16'd1 : sel;
`else
            x.rdy  = (m_since >= 1);
            x.addr = sel;
`endif
            sb.push_back(x);
        end
        // Effect of the coming rising edge.
        if (rst) begin
            m_known = 1'b1;
            m_since = 0;
`ifdef PC_VECTOR_FETCH_EN
            m_pc = '0;
`else
            m_pc = RESET_PC;
`endif
        end else if (m_known) begin
`ifdef PC_VECTOR_FETCH_EN
            if (m_since < 2) begin
                m_since++;
            end else if (m_since == 2) begin
                m_pc    = {mem[RST_VEC + 16'd1], mem[RST_VEC]};
                m_since = 3;
            end else begin
                m_pc = run_step(m_pc, p, ld, din);
            end
`else
            m_since = 1;
            m_pc    = run_step(m_pc, p, ld, din);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, PS_HOLD, MM_PC, 1'b0, 16'h0000, 16'h0BAD);
    endtask

    // Monitor: one scoreboard entry per cycle, sampled after inputs settle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("ready", 32'(ready), 32'(x.rdy));
                check("pc",    32'(pc),    32'(x.pc));
                check("addr",  32'(addr),  32'(x.addr));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        reset = 1'b1; ps = PS_HOLD; mm = MM_PC; pc_load = 1'b0; pc_din = '0; ea = '0;

        // Reset, then vector fetch while control inputs are junk.
        drive(1'b1, PS_HOLD, MM_PC, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, PS_INC,  MM_EA, 1'b1, 16'hDEAD, 16'hBEEF);
        drive(1'b0, PS_INC,  MM_EA, 1'b1, 16'h5555, 16'h0BAD);
        drive(1'b0, PS_INC,  MM_EA, 1'b1, 16'h6666, 16'h0BAD);
        drive(1'b0, PS_INC,  MM_EA, 1'b1, 16'h7777, 16'h0BAD);
        idle(2);

        // Increment three times, then hold.
        for (int i = 0; i < 3; i++) drive(1'b0, PS_INC, MM_PC, 1'b0, 16'h0000, 16'h0000);
        idle(2);

        // Wrap at the top of the address space.
        drive(1'b0, PS_HOLD, MM_PC, 1'b1, 16'hFFFF, 16'h0000);
        drive(1'b0, PS_INC,  MM_PC, 1'b0, 16'h0000, 16'h0000);
        idle(1);

        // Load wins over increment.
        drive(1'b0, PS_INC, MM_PC, 1'b1, 16'hC000, 16'h0000);
        idle(1);

        // Effective address select, then back to pc.
        drive(1'b0, PS_HOLD, MM_EA,  1'b0, 16'h0000, 16'h0200);
        drive(1'b0, PS_HOLD, 2'b11,  1'b0, 16'h0000, 16'h0300);
        idle(1);

        // Reset in mid-fetch, then again while running; reset beats load.
        drive(1'b1, PS_HOLD, MM_PC, 1'b0, 16'h0000, 16'h0000);
        drive(1'b0, PS_HOLD, MM_PC, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, PS_INC,  MM_PC, 1'b1, 16'hAAAA, 16'h0000);
        idle(5);
        drive(1'b1, PS_INC,  MM_PC, 1'b1, 16'hAAAA, 16'h0000);
        idle(5);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0), 2'($urandom), 2'($urandom),
                  ($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom));
        end
        idle(2);

        @(negedge clk);
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
